// File: rtl/nn_pkg.sv
// Shared constants and state encoding for the neural_net input sampling path.
package nn_pkg;
    localparam int NN_WIDTH = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;
endpackage

// File: rtl/nn_sync2.sv
// Per-bit two-flop synchronizer that brings asynchronous switch levels into the clk domain.
module nn_sync2
    import nn_pkg::*;
#(
    parameter int WIDTH = NN_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta_p0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_p0 <= '0;
            q       <= '0;
        end else begin
            meta_p0 <= d;
            q       <= meta_p0;
        end
    end
endmodule

// File: rtl/nn_input_sampler.sv
// Debounces DIP-switch levels and offers each newly settled word over valid/ready,
// counting accepted samples.
module nn_input_sampler
    import nn_pkg::*;
#(
    parameter int WIDTH           = NN_WIDTH,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [7:0]       sample_count
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] cand;
    logic [CNT_W-1:0] cnt;
    logic             stable;

    state_t           state, state_nxt;
    logic             have_sent, have_sent_nxt;
    logic [WIDTH-1:0] last_sent, last_sent_nxt;
    logic             valid_nxt;
    logic [WIDTH-1:0] data_nxt;
    logic [7:0]       count_nxt;

    nn_sync2 #(.WIDTH(WIDTH)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (sw_in),
        .q   (sync_q)
    );

    // Debounce: any change restarts the count; the count saturates once settled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand <= '0;
            cnt  <= '0;
        end else if (sync_q != cand) begin
            cand <= sync_q;
            cnt  <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign stable = (sync_q == cand) && (cnt == CNT_MAX);

    always_comb begin
        state_nxt     = state;
        valid_nxt     = out_valid;
        data_nxt      = out_data;
        last_sent_nxt = last_sent;
        have_sent_nxt = have_sent;
        count_nxt     = sample_count;
        case (state)
            ST_IDLE: begin
                if (stable && (!have_sent || cand != last_sent)) begin
                    data_nxt  = cand;
                    valid_nxt = 1'b1;
                    state_nxt = ST_OFFER;
                end
            end
            ST_OFFER: begin
                // The offered word is frozen here; later switch activity waits in cand/cnt.
                if (out_ready) begin
                    valid_nxt     = 1'b0;
                    last_sent_nxt = out_data;
                    have_sent_nxt = 1'b1;
                    count_nxt     = sample_count + 8'd1;
                    state_nxt     = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            out_valid    <= 1'b0;
            out_data     <= '0;
            last_sent    <= '0;
            have_sent    <= 1'b0;
            sample_count <= '0;
        end else begin
            state        <= state_nxt;
            out_valid    <= valid_nxt;
            out_data     <= data_nxt;
            last_sent    <= last_sent_nxt;
            have_sent    <= have_sent_nxt;
            sample_count <= count_nxt;
        end
    end
endmodule

// File: tb/tb_nn_input_sampler.sv
// Directed bench for nn_input_sampler with DEBOUNCE_CYCLES=4.
module tb_nn_input_sampler;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sw_in = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic [7:0] sample_count;

    int vectors = 0;
    int fails   = 0;
    int accepts = 0;
    int base;

    nn_input_sampler #(.WIDTH(8), .DEBOUNCE_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .sw_in        (sw_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .sample_count (sample_count)
    );

    always #5 clk = ~clk;

    // Handshakes seen on each rising edge (pre-edge values).
    always @(posedge clk) if (!rst && out_valid && out_ready) accepts++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic wait_valid(input int budget, input string tag);
        int n = 0;
        while (!out_valid && n < budget) begin
            step();
            n++;
        end
        check(tag, out_valid, 1);
    endtask

    initial begin
        logic [7:0] v;
        // Reset state
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 8'h00);
        check("rst_count", sample_count, 0);
        step(2);
        rst = 1'b0;

        // 1: zero is offered once after reset
        wait_valid(12, "t1_valid");
        check("t1_data", out_data, 8'h00);
        step();
        check("t1_drop", out_valid, 0);
        check("t1_count", sample_count, 1);
        base = accepts;
        step(12);
        check("t1_no_reoffer", accepts - base, 0);

        // 2: exact latency of a new value, single pulse
        base = accepts;
        sw_in = 8'h5A;
        step(6);
        check("t2_not_yet", out_valid, 0);
        step();
        check("t2_valid", out_valid, 1);
        check("t2_data", out_data, 8'h5A);
        step();
        check("t2_drop", out_valid, 0);
        step(10);
        check("t2_one_pulse", accepts - base, 1);
        check("t2_count", sample_count, 2);

        // 3: short glitch returning to the last sent value
        base = accepts;
        sw_in = 8'hFF;
        step(3);
        sw_in = 8'h5A;
        step(15);
        check("t3_no_offer", accepts - base, 0);
        check("t3_valid", out_valid, 0);
        check("t3_count", sample_count, 2);

        // 4: change during a stalled offer
        out_ready = 1'b0;
        sw_in = 8'h11;
        wait_valid(12, "t4_valid");
        check("t4_data", out_data, 8'h11);
        sw_in = 8'h22;
        step(12);
        check("t4_hold_valid", out_valid, 1);
        check("t4_hold_data", out_data, 8'h11);
        out_ready = 1'b1;
        step();
        check("t4_accept_drop", out_valid, 0);
        check("t4_count", sample_count, 3);
        step();
        check("t4_reoffer", out_valid, 1);
        check("t4_data2", out_data, 8'h22);
        step();
        check("t4_count2", sample_count, 4);

        // 5: asynchronous reset during an offer
        out_ready = 1'b0;
        sw_in = 8'h33;
        wait_valid(12, "t5_valid");
        check("t5_data", out_data, 8'h33);
        #2 rst = 1'b1;
        #1;
        check("t5_async_valid", out_valid, 0);
        check("t5_async_count", sample_count, 0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        wait_valid(14, "t5_revalid");
        check("t5_redata", out_data, 8'h33);
        step();
        check("t5_count", sample_count, 1);

        // 6: sample_count wrap
        for (int i = 0; i < 255; i++) begin
            v = 8'(i) ^ 8'h80;
            sw_in = v;
            wait_valid(14, "t6_valid");
            step();
        end
        check("t6_wrap", sample_count, 0);
        sw_in = 8'h55;
        wait_valid(14, "t6_last_valid");
        check("t6_last_data", out_data, 8'h55);
        step();
        check("t6_after_wrap", sample_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
